// File: rtl/mem_image_loader.sv
// mem_image_loader: streams program/data words onto the core's memory-load buses and holds the load enable
// until both images and a flush window are written; `define LOADER_CHECKSUM_EN adds a trailing checksum word.
module mem_image_loader #(
   parameter int ADDR_W       = 9,
   parameter int WORD_W       = 32,
   parameter int CNT_W        = 9,
   parameter int ADDR_STEP    = 8,
   parameter int FLUSH_CYCLES = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [CNT_W-1:0]  inst_words,
   input  logic [CNT_W-1:0]  data_words,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [WORD_W-1:0] s_data,
   output logic              enable_load_ex_mem,
   output logic [ADDR_W-1:0] inst_addr,
   output logic [WORD_W-1:0] inst_data1,
   output logic [WORD_W-1:0] inst_data2,
   output logic [ADDR_W-1:0] data_addr,
   output logic [WORD_W-1:0] data_data1,
   output logic [WORD_W-1:0] data_data2,
   output logic              busy,
   output logic              done,
   output logic              error
);
   typedef enum logic [2:0] {IDLE, INST, DATA, CSUM, FLUSH} state_t;
   localparam int FW = $clog2(FLUSH_CYCLES);
`ifdef LOADER_CHECKSUM_EN
   localparam state_t AFTER = CSUM;
`else
   localparam state_t AFTER = FLUSH;
`endif
   state_t            r_state, w_next;
   logic [CNT_W-1:0]  r_rem, r_data_cnt;
   logic [ADDR_W-1:0] r_pair, w_addr;
   logic [WORD_W-1:0] r_buf;
   logic              r_half;
   logic [FW-1:0]     r_flush;
   logic              w_acc, w_last, w_load, w_pair;
   always_comb begin
      w_acc  = s_valid && s_ready;
      w_last = r_rem == CNT_W'(1);
      w_load = w_acc && (r_state == INST || r_state == DATA);
      w_pair = w_load && (r_half || w_last);
      w_addr = r_pair * ADDR_W'(ADDR_STEP);
      w_next = r_state;
      case (r_state)
         IDLE:    if (start) w_next = inst_words != '0 ? INST : data_words != '0 ? DATA : AFTER;
         INST:    if (w_load && w_last) w_next = r_data_cnt != '0 ? DATA : AFTER;
         DATA:    if (w_load && w_last) w_next = AFTER;
         CSUM:    if (w_acc) w_next = FLUSH;
         default: if (r_flush == '0) w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state            <= IDLE;
         s_ready            <= 1'b0;
         busy               <= 1'b0;
         enable_load_ex_mem <= 1'b0;
         done               <= 1'b0;
         r_rem              <= '0;
         r_data_cnt         <= '0;
         r_pair             <= '0;
         r_buf              <= '0;
         r_half             <= 1'b0;
         r_flush            <= '0;
         inst_addr          <= '0;
         inst_data1         <= '0;
         inst_data2         <= '0;
         data_addr          <= '0;
         data_data1         <= '0;
         data_data2         <= '0;
      end else begin
         r_state            <= w_next;
         s_ready            <= w_next == INST || w_next == DATA || w_next == CSUM;
         busy               <= w_next != IDLE;
         enable_load_ex_mem <= w_next != IDLE;
         done               <= r_state == FLUSH && w_next == IDLE;
         r_flush            <= r_state != FLUSH ? FW'(FLUSH_CYCLES - 1) : r_flush - 1'b1;
         if (r_state == IDLE && start) begin
            r_rem      <= inst_words != '0 ? inst_words : data_words;
            r_data_cnt <= data_words;
            r_pair     <= '0;
            r_half     <= 1'b0;
            inst_addr  <= '0;
            inst_data1 <= '0;
            inst_data2 <= '0;
            data_addr  <= '0;
            data_data1 <= '0;
            data_data2 <= '0;
         end
         if (w_load) begin
            r_buf  <= s_data;
            r_half <= !w_pair;
            r_rem  <= w_last ? r_data_cnt : r_rem - 1'b1;
            // an odd region's last word closes a pair on its own, with a zero odd half
            if (w_pair) begin
               r_pair <= w_last ? '0 : r_pair + 1'b1;
               if (r_state == INST) begin
                  inst_addr  <= w_addr;
                  inst_data1 <= r_half ? r_buf : s_data;
                  inst_data2 <= r_half ? s_data : '0;
               end else begin
                  data_addr  <= w_addr;
                  data_data1 <= r_half ? r_buf : s_data;
                  data_data2 <= r_half ? s_data : '0;
               end
            end
         end
      end
   end
`ifdef LOADER_CHECKSUM_EN
   logic [WORD_W-1:0] r_sum;
   logic              r_error;
   always_ff @(posedge clk) begin
      if (reset || (r_state == IDLE && start)) begin
         r_sum   <= '0;
         r_error <= 1'b0;
      end else if (w_acc) begin
         if (r_state == CSUM) r_error <= r_error || s_data != r_sum;
         else r_sum <= r_sum + s_data;
      end
   end
   assign error = r_error;
`else
   assign error = 1'b0;
`endif
endmodule

// File: tb/tb_mem_image_loader.sv
// tb_mem_image_loader: randomized directed loads checked against a word-index model of the load buses.
module tb_mem_image_loader;
   localparam int ADDR_W = 9, WORD_W = 32, CNT_W = 9, ADDR_STEP = 8, FLUSH_CYCLES = 4;
`ifdef LOADER_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif
   logic clk = 1'b0, reset = 1'b1, start = 1'b0, s_valid = 1'b0;
   logic [CNT_W-1:0] inst_words = '0, data_words = '0;
   logic [WORD_W-1:0] s_data = '0;
   logic s_ready, enable_load_ex_mem, busy, done, error;
   logic [ADDR_W-1:0] inst_addr, data_addr;
   logic [WORD_W-1:0] inst_data1, inst_data2, data_data1, data_data2;
   logic [72:0] ibus, dbus;
   int compared = 0, mismatched = 0;

   mem_image_loader dut (
      .clk(clk), .reset(reset), .start(start), .inst_words(inst_words), .data_words(data_words),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .enable_load_ex_mem(enable_load_ex_mem),
      .inst_addr(inst_addr), .inst_data1(inst_data1), .inst_data2(inst_data2),
      .data_addr(data_addr), .data_data1(data_data1), .data_data2(data_data2),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;
   assign ibus = {inst_addr, inst_data1, inst_data2};
   assign dbus = {data_addr, data_data1, data_data2};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic run_load(input int ni, input int nd, input int gap, input bit noise, input bit bad);
      logic [31:0] w[$];
      logic [31:0] sum;
      logic [72:0] ei, ed, e;
      logic ee;
      int k, n;
      sum = 0; ei = '0; ed = '0; ee = 1'b0;
      for (int i = 0; i < ni + nd; i++) begin
         w.push_back($urandom);
         sum += w[i];
      end
      inst_words = CNT_W'(ni);
      data_words = CNT_W'(nd);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_ctrl", {enable_load_ex_mem, busy, done}, 3'b110);
      chk("start_ready", s_ready, (ni + nd > 0) || CS);
      chk("start_clear", {ibus, dbus, error}, '0);
      for (int i = 0; i < ni + nd; i++) begin
         k = i < ni ? i : i - ni;
         n = i < ni ? ni : nd;
         for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            tick();
            chk("gap_hold", {ibus, dbus, enable_load_ex_mem}, {ei, ed, 1'b1});
         end
         if (noise) begin
            start = 1'b1;
            inst_words = CNT_W'($urandom);
            data_words = CNT_W'($urandom);
         end
         chk("word_ready", s_ready, 1'b1);
         s_valid = 1'b1;
         s_data = w[i];
         tick();
         s_valid = 1'b0;
         start = 1'b0;
         if (k % 2 == 1 || k == n - 1) begin
            e = {ADDR_W'((k / 2) * ADDR_STEP), w[i - k % 2], k % 2 == 1 ? w[i] : 32'h0};
            if (i < ni) ei = e;
            else ed = e;
         end
         chk("accept_bus", {ibus, dbus}, {ei, ed});
      end
`ifdef LOADER_CHECKSUM_EN
      chk("csum_ready", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data = bad ? sum + 32'd1 : sum;
      tick();
      s_valid = 1'b0;
      ee = bad;
`endif
      for (int c = 0; c < FLUSH_CYCLES; c++) begin
         if (c > 0) tick();
         chk("flush_ctrl", {enable_load_ex_mem, busy, s_ready, done, error}, {4'b1100, ee});
         chk("flush_bus", {ibus, dbus}, {ei, ed});
      end
      tick();
      chk("done_ctrl", {enable_load_ex_mem, busy, s_ready, done, error}, {4'b0001, ee});
      tick();
      chk("idle_ctrl", {enable_load_ex_mem, busy, s_ready, done}, 4'b0000);
      chk("idle_bus", {ibus, dbus}, {ei, ed});
   endtask

   initial begin
      tick();
      tick();
      chk("reset_outs", {enable_load_ex_mem, s_ready, busy, done, error, ibus, dbus}, '0);
      reset = 1'b0;
      tick();
      chk("idle_outs", {enable_load_ex_mem, s_ready, busy, done, error, ibus, dbus}, '0);
      run_load(3, 2, 0, 1'b0, 1'b0);
      run_load(0, 0, 0, 1'b0, 1'b0);
      run_load(4, 0, 3, 1'b0, 1'b0);
      inst_words = CNT_W'(4);
      data_words = '0;
      start = 1'b1;
      tick();
      start = 1'b0;
      s_valid = 1'b1;
      s_data = $urandom;
      tick();
      s_valid = 1'b0;
      reset = 1'b1;
      tick();
      chk("abort_outs", {enable_load_ex_mem, s_ready, busy, done, error, ibus, dbus}, '0);
      reset = 1'b0;
      tick();
      chk("after_abort", {enable_load_ex_mem, s_ready, busy, done}, 4'b0000);
      run_load(2, 0, 0, 1'b1, 1'b0);
      run_load(130, 0, 0, 1'b0, 1'b0);
      chk("wrap_addr", inst_addr, '0);
      run_load(0, 3, 1, 1'b0, 1'b0);
      for (int r = 0; r < 6; r++)
         run_load(int'($urandom_range(0, 9)), int'($urandom_range(0, 9)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
`ifdef LOADER_CHECKSUM_EN
      run_load(2, 1, 0, 1'b0, 1'b0);
      run_load(2, 1, 0, 1'b0, 1'b1);
      run_load(1, 0, 0, 1'b0, 1'b0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
